// File: rtl/key_streamer.sv
// Key byte streamer: buffers up to DEPTH key bytes, resets the validator for one
// cycle, streams bytes 0..len-1 one per clock, then captures the validator verdict.
module key_streamer #(
  parameter int              WIDTH = 8,
  parameter int              DEPTH = 32,
  parameter logic [WIDTH-1:0] FILL = 8'hEB,
  parameter int              LW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clear,
  input  logic             start,
  input  logic [LW-1:0]    len,
  output logic [LW-1:0]    count,
  output logic             full,
  output logic             busy,
  output logic             err,
  output logic [WIDTH-1:0] out,
  output logic             vrst,
  input  logic [WIDTH-1:0] result_in,
  output logic             done,
  output logic             pass,
  output logic             fail
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, ARM, SEND, FLUSH, CHECK} state_t;

  state_t           state_q, state_d;
  logic [LW-1:0]    count_q, count_d;
  logic [LW-1:0]    len_q, len_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             vrst_q, vrst_d, busy_q, busy_d, full_q, full_d;
  logic             err_q, err_d, done_q, done_d, pass_q, pass_d, fail_q, fail_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic is_idle, start_ok, wr_fire, last_byte;

  assign is_idle   = (state_q == IDLE);
  // Length check uses the count before any same-cycle append.
  assign start_ok  = is_idle && start && (len != '0) && (len <= count_q);
  assign wr_fire   = is_idle && wr_en && !clear && !full_q;
  assign last_byte = ({1'b0, idx_q} == len_q - LW'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      count_q <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      out_q   <= FILL;
      vrst_q  <= 1'b1;
      busy_q  <= 1'b0;
      full_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      vrst_q  <= vrst_d;
      busy_q  <= busy_d;
      full_q  <= full_d;
      err_q   <= err_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[count_q[AW-1:0]] <= wr_data;
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    len_d   = len_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (clear)        count_d = '0;
        else if (wr_fire) count_d = count_q + LW'(1);
        if (start_ok) begin
          len_d   = len;
          idx_d   = '0;
          state_d = ARM;
        end
      end
      // The ARM->SEND edge already drives byte 0, so ARM also advances idx.
      ARM, SEND: begin
        if (last_byte) state_d = FLUSH;
        else begin
          idx_d   = idx_q + AW'(1);
          state_d = SEND;
        end
      end
      FLUSH:   state_d = CHECK;
      CHECK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    out_d  = out_q;
    pass_d = pass_q;
    fail_d = fail_q;
    vrst_d = (state_d == ARM);
    busy_d = (state_d != IDLE);
    full_d = (count_d == LW'(DEPTH));
    err_d  = is_idle && start && !start_ok;
    done_d = (state_q == CHECK);
    unique case (state_q)
      IDLE: begin
        out_d = FILL;
        if (start_ok) begin
          pass_d = 1'b0;
          fail_d = 1'b0;
        end
      end
      ARM, SEND: out_d = mem_q[idx_q];
      FLUSH:     out_d = FILL;
      CHECK: begin
        pass_d = (result_in != '0);
        fail_d = (result_in == '0);
      end
      default: out_d = FILL;
    endcase
  end

  assign count = count_q;
  assign full  = full_q;
  assign busy  = busy_q;
  assign err   = err_q;
  assign out   = out_q;
  assign vrst  = vrst_q;
  assign done  = done_q;
  assign pass  = pass_q;
  assign fail  = fail_q;
endmodule

// File: tb/tb_key_streamer.sv
// Bench for key_streamer: a scoreboard of expected stream bytes and verdicts,
// a three-byte reference validator, and directed load/start sequences.
module tb_key_streamer;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       wr_en = 1'b0, clear = 1'b0, start = 1'b0;
  logic [7:0] wr_data = '0;
  logic [5:0] len = '0;
  logic [5:0] count;
  logic       full, busy, err, vrst, done, pass, fail;
  logic [7:0] out, result_in;

  key_streamer dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_data(wr_data),
    .clear(clear), .start(start), .len(len), .count(count), .full(full),
    .busy(busy), .err(err), .out(out), .vrst(vrst), .result_in(result_in),
    .done(done), .pass(pass), .fail(fail)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference validator: expects key 00 A4 B8, counter cleared by vrst.
  logic [7:0] vkey [3] = '{8'h00, 8'hA4, 8'hB8};
  int   vcnt;
  logic vok;
  always @(posedge clk) begin
    if (vrst) begin
      vcnt <= 0;
      vok  <= 1'b1;
    end else begin
      if (vcnt < 3) vok <= vok && (out == vkey[vcnt]);
      if (vcnt < 255) vcnt <= vcnt + 1;
    end
  end
  assign result_in = (vok && vcnt >= 3) ? 8'h01 : 8'h00;

  // Scoreboard: {last, byte} stream entries and {pass, fail} verdicts.
  logic [8:0] exp_q [$];
  logic [1:0] ver_q [$];
  logic       mon_en = 1'b1;
  logic       streaming = 1'b0;

  always @(negedge clk) begin
    if (mon_en && reset_n) begin
      if (streaming) begin
        if (exp_q.size() == 0) check("stream_extra", 32'd1, 32'd0);
        else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          check("stream_byte", {24'd0, out}, {24'd0, e[7:0]});
          check("stream_vrst", {31'd0, vrst}, 32'd0);
          if (e[8]) streaming = 1'b0;
        end
      end else if (vrst && busy) streaming = 1'b1;
      if (done) begin
        if (ver_q.size() == 0) check("verdict_extra", 32'd1, 32'd0);
        else begin
          logic [1:0] v;
          v = ver_q.pop_front();
          check("verdict", {30'd0, pass, fail}, {30'd0, v});
        end
      end
    end
  end

  // Bench-side copy of the buffer contents, filled by write_byte.
  logic [7:0] key_m [32];
  int         cnt_m = 0;

  task automatic write_byte(input logic [7:0] b);
    @(negedge clk);
    wr_en = 1'b1; wr_data = b;
    @(negedge clk);
    wr_en = 1'b0;
    if (cnt_m < 32) begin key_m[cnt_m] = b; cnt_m++; end
  endtask

  task automatic do_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    cnt_m = 0;
  endtask

  task automatic pulse_start(input logic [5:0] l);
    @(negedge clk); start = 1'b1; len = l;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic expect_run(input int n, input logic [1:0] v);
    for (int i = 0; i < n; i++) exp_q.push_back({1'b0, key_m[i]});
    exp_q.push_back({1'b1, 8'hEB});
    ver_q.push_back(v);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 200) begin @(negedge clk); t++; end
    if (busy) check("idle_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_out",   {24'd0, out}, 32'hEB);
    check("rst_vrst",  {31'd0, vrst}, 32'd1);
    check("rst_count", {26'd0, count}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_pf",    {30'd0, pass, fail}, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    check("vrst_fall", {31'd0, vrst}, 32'd0);

    // Load and send a matching key
    write_byte(8'h00); write_byte(8'hA4); write_byte(8'hB8);
    check("count3", {26'd0, count}, 32'd3);
    expect_run(3, 2'b10);
    pulse_start(6'd3);
    check("start_err0", {31'd0, err}, 32'd0);
    check("start_busy", {31'd0, busy}, 32'd1);
    check("arm_vrst",   {31'd0, vrst}, 32'd1);
    begin
      int t;
      t = 0;
      while (!done && t < 50) begin @(negedge clk); t++; end
      check("done_edge_len3", t, 32'd5);
    end
    wait_idle();

    // Mismatching key, then replay without reload
    do_clear();
    write_byte(8'h00); write_byte(8'h11); write_byte(8'hB8);
    expect_run(3, 2'b01);
    pulse_start(6'd3);
    wait_idle();
    expect_run(3, 2'b01);
    pulse_start(6'd3);
    check("replay_pf_cleared", {30'd0, pass, fail}, 32'd0);
    wait_idle();

    // Rejected starts
    pulse_start(6'd0);
    check("err_len0", {31'd0, err}, 32'd1);
    @(negedge clk);
    check("err_one_cycle", {31'd0, err}, 32'd0);
    pulse_start(6'd4);
    check("err_len_gt", {31'd0, err}, 32'd1);
    check("err_busy",   {31'd0, busy}, 32'd0);
    check("err_hold_pf", {30'd0, pass, fail}, 32'd1);
    // start during SEND is ignored
    expect_run(3, 2'b01);
    pulse_start(6'd3);
    pulse_start(6'd1);
    check("send_start_err", {31'd0, err}, 32'd0);
    check("send_start_busy", {31'd0, busy}, 32'd1);
    wait_idle();

    // Full buffer: 33 writes, 33rd dropped, then a 32-byte run
    do_clear();
    for (int i = 0; i < 33; i++) write_byte(8'h40 + 8'(i));
    check("full_count", {26'd0, count}, 32'd32);
    check("full_flag",  {31'd0, full}, 32'd1);
    expect_run(32, 2'b01);
    pulse_start(6'd32);
    begin
      int t;
      t = 0;
      while (!done && t < 100) begin @(negedge clk); t++; end
      check("done_edge_len32", t, 32'd34);
    end
    wait_idle();

    // Same-cycle events
    do_clear();
    write_byte(8'h01);
    @(negedge clk); wr_en = 1'b1; clear = 1'b1; wr_data = 8'h02;
    @(negedge clk); wr_en = 1'b0; clear = 1'b0;
    cnt_m = 0;
    check("wr_clear_count", {26'd0, count}, 32'd0);
    check("not_full", {31'd0, full}, 32'd0);
    write_byte(8'h00); write_byte(8'hA4);
    @(negedge clk); wr_en = 1'b1; wr_data = 8'hB8; start = 1'b1; len = 6'd3;
    @(negedge clk); wr_en = 1'b0; start = 1'b0;
    key_m[cnt_m] = 8'hB8; cnt_m++;
    check("wr_start_err",   {31'd0, err}, 32'd1);
    check("wr_start_count", {26'd0, count}, 32'd3);
    check("wr_start_busy",  {31'd0, busy}, 32'd0);
    expect_run(3, 2'b10);
    pulse_start(6'd3);
    wait_idle();

    // Reset mid-SEND
    mon_en = 1'b0;
    pulse_start(6'd3);
    @(negedge clk); @(negedge clk);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_out",  {24'd0, out}, 32'hEB);
    check("mid_rst_vrst", {31'd0, vrst}, 32'd1);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_count", {26'd0, count}, 32'd0);
    check("post_rst_vrst",  {31'd0, vrst}, 32'd0);
    repeat (6) begin
      @(negedge clk);
      check("post_rst_no_done", {31'd0, done}, 32'd0);
    end

    check("exp_q_drained", exp_q.size(), 32'd0);
    check("ver_q_drained", ver_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/key_streamer.md
# key_streamer

Transmit end of the license-check byte stream. Holds a key of up to DEPTH bytes loaded over a simple write port, then drives it into the validator one byte per clock, byte 0 first. It resets the validator immediately before the first byte so the validator's byte counter is aligned. After the last byte it samples the validator's verdict and reports pass/fail.

## Interface
- WIDTH, 8, byte width of stream and storage
- DEPTH, 32, key buffer entries (power of two)
- FILL, 8'hEB, idle/filler byte driven on `out` when not sending
- LW, $clog2(DEPTH)+1, width of `len` and `count`

Ports:
- clk  in  1  single clock, all state on rising edge
- reset_n  in  1  reset, asynchronous and active-low
- wr_en  in  1  write strobe for key buffer
- wr_data  in  WIDTH  key byte to append
- clear  in  1  empty key buffer (IDLE only)
- start  in  1  request transmission of `len` bytes
- len  in  LW  bytes to send, valid 1..count
- count  out  LW  bytes currently stored
- full  out  1  count == DEPTH
- busy  out  1  state != IDLE
- err  out  1  one-cycle pulse: start rejected
- out  out  WIDTH  stream byte to validator `in`
- vrst  out  1  active-high reset to validator
- result_in  in  WIDTH  validator `out`
- done  out  1  one-cycle pulse: verdict captured
- pass  out  1  last verdict nonzero
- fail  out  1  last verdict zero

## Operation
- States: IDLE, ARM, SEND, FLUSH, CHECK. All outputs registered.
- Reset values: state=IDLE, count=0, idx=0, out=FILL, vrst=1, busy=0, err=0, done=0, pass=0, fail=0. Buffer contents are not reset.
- IDLE:
  - vrst=0 and out=FILL.
  - wr_en with !full writes buf[count] and increments count. wr_en when full is dropped.
  - clear sets count=0 and has priority over wr_en in the same cycle.
- start in IDLE:
  - Accepted if 1 <= len <= count, where count is the value before any same-cycle write. Latches len, idx=0, clears pass/fail, and moves to ARM.
  - Otherwise err pulses and the block stays in IDLE.
- ARM (1 cycle): vrst=1. Moves to SEND.
- SEND:
  - vrst=0. Each edge drives out<=buf[idx] and increments idx.
  - On the edge that drives buf[len-1], moves to FLUSH.
- FLUSH (1 cycle): out<=FILL. Moves to CHECK.
- CHECK (1 cycle):
  - Samples result_in: pass<=(result_in!=0), fail<=(result_in==0).
  - done pulses and the block returns to IDLE.
- While busy: wr_en, clear and start are ignored. start while busy does not pulse err.
- The buffer is retained after a run, so the same key can be replayed with another start.
- pass/fail hold until the next accepted start.
- idx never exceeds len-1. len is latched and ignored after acceptance.

## Timing
- Accepting edge E0 (start sampled in IDLE).
- vrst=1 during the cycle after E0. The validator resets at E1.
- out=buf[k] is valid after edge E1+k, for k=0..len-1. The validator samples buf[k] at E2+k, with its counter at k.
- out=FILL after E(len+1). The validator verdict is stable during CHECK.
- done, pass and fail are updated at E(len+2). busy is high from E0 through E(len+2).
- Throughput: one key byte per clock. Minimum start-to-start spacing is len+3 cycles.
- reset_n asserted at any point: outputs return to reset values immediately, including vrst=1, which holds the validator in reset. Any in-flight run is abandoned with no done pulse.
- vrst falls at the first clk edge after reset_n deasserts.

## Test plan
- Reset: hold reset_n=0 mid-SEND -> out=8'hEB, vrst=1, busy=0, done=0 immediately. After release, count=0.
- Load and send: write 8'h00, 8'hA4, 8'hB8, start len=3 -> err=0. vrst high 1 cycle, then out sequence 00, A4, B8, EB. With the validator attached, done at E5 with pass=1, fail=0.
- Mismatch: same load, but byte 1 = 8'h11 -> done with pass=0, fail=1. A replay start with no reload repeats the identical byte sequence.
- Rejects: start with len=0 -> err pulse. Start with len=4 when count=3 -> err pulse, busy=0. start during SEND -> no effect, no err.
- Full buffer: write 33 bytes -> count=32, full=1, 33rd byte dropped. Then start len=32 -> 32 bytes in write order, done 34 edges after the accepting edge.
- Same-cycle events: wr_en+clear in IDLE -> count=0. wr_en+start with count=2, len=3 -> err pulse, count=3.
